// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle RV32I datapath sharing one memory port between fetch and load/store.
// Optional performance counters are enabled by defining MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               run,
    input  logic [6:0]         opcode,
    input  logic               branch_taken,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               mem_addr_sel,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic               reg_write,
    output logic [1:0]         wb_sel,
    output logic               busy,
    output logic               illegal_insn,
    output logic [STATE_W-1:0] dbg_state
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0]        perf_cycles,
    output logic [31:0]        perf_instret
`endif
);

    typedef enum logic [STATE_W-1:0] {
        S_IDLE     = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_EXEC_R = 4'd3,
        S_EXEC_I   = 4'd4,  S_WB_ALU = 4'd5,  S_MEM_ADDR = 4'd6, S_MEM_RD = 4'd7,
        S_MEM_WB   = 4'd8,  S_MEM_WR = 4'd9,  S_BRANCH = 4'd10, S_JAL    = 4'd11,
        S_JALR     = 4'd12, S_TRAP   = 4'd13
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       pc_write;
        logic       in_fetch;
        logic       in_branch;
        logic [1:0] pc_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       busy;
        logic       illegal;
    } ctl_t;

    state_t r_state;
    state_t w_next;
    ctl_t   r_ctl;

    // Moore part of the control word for a state; precomputed from the next state so outputs come from flops.
    function automatic ctl_t decode_ctl(input state_t s);
        ctl_t c;
        c      = '0;
        c.busy = (s != S_IDLE) && (s != S_TRAP);
        case (s)
            S_FETCH:    begin c.mem_req = 1'b1; c.in_fetch = 1'b1; end
            S_DECODE:   begin c.alu_src_a = 2'd1; c.alu_src_b = 2'd1; end
            S_EXEC_R:   begin c.alu_src_a = 2'd2; c.alu_op = 2'b10; end
            S_EXEC_I:   begin c.alu_src_a = 2'd2; c.alu_src_b = 2'd1; c.alu_op = 2'b11; end
            S_WB_ALU:   c.reg_write = 1'b1;
            S_MEM_ADDR: begin c.alu_src_a = 2'd2; c.alu_src_b = 2'd1; end
            S_MEM_RD:   begin c.mem_req = 1'b1; c.mem_addr_sel = 1'b1; end
            S_MEM_WB:   begin c.reg_write = 1'b1; c.wb_sel = 2'd1; end
            S_MEM_WR:   begin c.mem_req = 1'b1; c.mem_we = 1'b1; c.mem_addr_sel = 1'b1; end
            S_BRANCH:   begin
                c.alu_src_a = 2'd2; c.alu_op = 2'b01; c.pc_src = 2'd1; c.in_branch = 1'b1;
            end
            S_JAL:      begin c.pc_write = 1'b1; c.pc_src = 2'd1; c.reg_write = 1'b1; c.wb_sel = 2'd2; end
            S_JALR:     begin
                c.alu_src_a = 2'd2; c.alu_src_b = 2'd1;
                c.pc_write = 1'b1; c.pc_src = 2'd2; c.reg_write = 1'b1; c.wb_sel = 2'd2;
            end
            S_TRAP:     c.illegal = 1'b1;
            default:    c = '0;
        endcase
        return c;
    endfunction

    // Next-state selection; instruction completion returns to FETCH or parks in IDLE depending on run.
    always_comb begin
        state_t w_done;
        w_done = run ? S_FETCH : S_IDLE;
        w_next = r_state;
        case (r_state)
            S_IDLE:     w_next = run ? S_FETCH : S_IDLE;
            S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    7'b0110011:             w_next = S_EXEC_R;
                    7'b0010011:             w_next = S_EXEC_I;
                    7'b0000011, 7'b0100011: w_next = S_MEM_ADDR;
                    7'b1100011:             w_next = S_BRANCH;
                    7'b1101111:             w_next = S_JAL;
                    7'b1100111:             w_next = S_JALR;
                    default:                w_next = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_I: w_next = S_WB_ALU;
            S_MEM_ADDR: w_next = opcode[5] ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   w_next = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   w_next = mem_ready ? w_done : S_MEM_WR;
            S_WB_ALU, S_MEM_WB, S_BRANCH, S_JAL, S_JALR: w_next = w_done;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_IDLE;
        endcase
    end

    // State and registered control word; async reset abandons any in-flight memory request.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_ctl   <= '0;
        end else begin
            r_state <= w_next;
            r_ctl   <= decode_ctl(w_next);
        end
    end

    assign mem_req      = r_ctl.mem_req;
    assign mem_we       = r_ctl.mem_we;
    assign mem_addr_sel = r_ctl.mem_addr_sel;
    // FETCH completion and taken branches are the only input-dependent (Mealy) terms.
    assign ir_write     = r_ctl.in_fetch & mem_ready;
    assign pc_write     = r_ctl.pc_write | (r_ctl.in_fetch & mem_ready) | (r_ctl.in_branch & branch_taken);
    assign pc_src       = r_ctl.pc_src;
    assign alu_src_a    = r_ctl.alu_src_a;
    assign alu_src_b    = r_ctl.alu_src_b;
    assign alu_op       = r_ctl.alu_op;
    assign reg_write    = r_ctl.reg_write;
    assign wb_sel       = r_ctl.wb_sel;
    assign busy         = r_ctl.busy;
    assign illegal_insn = r_ctl.illegal;
    assign dbg_state    = r_state;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic        w_retire;
    logic [31:0] r_perf_cycles;
    logic [31:0] r_perf_instret;

    // An instruction retires on the cycle its final state hands off to FETCH/IDLE.
    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            S_WB_ALU, S_MEM_WB, S_BRANCH, S_JAL, S_JALR: w_retire = 1'b1;
            S_MEM_WR: w_retire = mem_ready;
            default:  w_retire = 1'b0;
        endcase
    end

    // Free-running busy-cycle and retired-instruction counters, wrapping naturally.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_perf_cycles  <= 32'd0;
            r_perf_instret <= 32'd0;
        end else begin
            r_perf_cycles  <= r_perf_cycles + {31'd0, r_ctl.busy};
            r_perf_instret <= r_perf_instret + {31'd0, w_retire};
        end
    end

    assign perf_cycles  = r_perf_cycles;
    assign perf_instret = r_perf_instret;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected states are queued, then popped and checked.
module tb_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        rstn;
    logic        run;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        mem_ready;
    logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write, busy, illegal_insn;
    logic [1:0]  pc_src, alu_src_a, alu_src_b, alu_op, wb_sel;
    logic [3:0]  dbg_state;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] perf_cycles, perf_instret;
    int          exp_cycles = 0;
    int          exp_instret = 0;
`endif

    always #5 clk = ~clk;

    multicycle_ctrl #(.STATE_W(4)) dut (
        .clk(clk), .rstn(rstn), .run(run), .opcode(opcode),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .wb_sel(wb_sel), .busy(busy),
        .illegal_insn(illegal_insn), .dbg_state(dbg_state)
`ifdef MULTICYCLE_CTRL_PERF_EN
        , .perf_cycles(perf_cycles), .perf_instret(perf_instret)
`endif
    );

    logic [17:0] act;
    assign act = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
                  alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, busy, illegal_insn};

    typedef struct {
        logic [3:0] st;
        logic       run;
        logic       rdy;
        logic       tk;
        logic [6:0] op;
    } step_t;

    step_t      q[$];
    int         checks = 0;
    int         failures = 0;
    int         rd_hold = 0;
    logic [6:0] cur_op = 7'd0;
    logic       cur_run = 1'b0;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                           OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BAD = 7'b0000000;

    // Expected output word for a state, written from the output table of the controller.
    function automatic logic [17:0] model(input logic [3:0] st, input logic rdy, input logic tk);
        logic mreq, mwe, msel, irw, pcw, rw, bsy, ill;
        logic [1:0] psrc, a, b, op, wb;
        {mreq, mwe, msel, irw, pcw, rw, ill} = 7'd0;
        {psrc, a, b, op, wb} = 10'd0;
        bsy = (st >= 4'd1) && (st <= 4'd12);
        case (st)
            4'd1:  begin mreq = 1'b1; irw = rdy; pcw = rdy; end
            4'd2:  begin a = 2'd1; b = 2'd1; end
            4'd3:  begin a = 2'd2; b = 2'd0; op = 2'b10; end
            4'd4:  begin a = 2'd2; b = 2'd1; op = 2'b11; end
            4'd5:  begin rw = 1'b1; wb = 2'd0; end
            4'd6:  begin a = 2'd2; b = 2'd1; op = 2'b00; end
            4'd7:  begin mreq = 1'b1; msel = 1'b1; end
            4'd8:  begin rw = 1'b1; wb = 2'd1; end
            4'd9:  begin mreq = 1'b1; mwe = 1'b1; msel = 1'b1; end
            4'd10: begin a = 2'd2; b = 2'd0; op = 2'b01; pcw = tk; psrc = 2'd1; end
            4'd11: begin pcw = 1'b1; psrc = 2'd1; rw = 1'b1; wb = 2'd2; end
            4'd12: begin a = 2'd2; b = 2'd1; pcw = 1'b1; psrc = 2'd2; rw = 1'b1; wb = 2'd2; end
            4'd13: ill = 1'b1;
            default: ;
        endcase
        return {mreq, mwe, msel, irw, pcw, psrc, a, b, op, rw, wb, bsy, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic rdy, input logic tk);
        step_t s;
        s.st = st; s.run = cur_run; s.rdy = rdy; s.tk = tk; s.op = cur_op;
        q.push_back(s);
    endtask

    // Drive each queued step just after a rising edge, compare at the falling edge.
    task automatic run_queue();
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            run = s.run; mem_ready = s.rdy; branch_taken = s.tk; opcode = s.op;
            @(negedge clk);
            check($sformatf("state_exp%0d", s.st), {28'd0, dbg_state}, {28'd0, s.st});
            check($sformatf("outs_st%0d", s.st), {14'd0, act}, {14'd0, model(s.st, s.rdy, s.tk)});
            if (mem_req && mem_addr_sel && !mem_we) rd_hold++;
`ifdef MULTICYCLE_CTRL_PERF_EN
            if (model(s.st, s.rdy, s.tk)[1]) exp_cycles++;
            if ((s.st inside {4'd5, 4'd8, 4'd10, 4'd11, 4'd12}) || (s.st == 4'd9 && s.rdy)) exp_instret++;
`endif
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_short(input logic [6:0] op, input logic [3:0] exec_st, input logic tk);
        cur_op = op;
        push(4'd1, 1'b1, 1'b0);
        push(4'd2, 1'b0, 1'b0);
        push(exec_st, 1'b0, tk);
    endtask

    initial begin
        rstn = 1'b1; run = 1'b0; opcode = 7'd0; branch_taken = 1'b0; mem_ready = 1'b0;
        #1 rstn = 1'b0;
        repeat (2) @(posedge clk);
        run = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        check("rst_state", {28'd0, dbg_state}, 32'd0);
        check("rst_outs", {14'd0, act}, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;

        cur_run = 1'b1;
        push(4'd0, 1'b1, 1'b0);
        // R-type, zero wait
        cur_op = OP_R;
        push(4'd1, 1'b1, 1'b0); push(4'd2, 1'b0, 1'b0); push(4'd3, 1'b0, 1'b0); push(4'd5, 1'b0, 1'b0);
        // I-type with a stray mem_ready outside any request
        cur_op = OP_I;
        push(4'd1, 1'b1, 1'b0); push(4'd2, 1'b1, 1'b0); push(4'd4, 1'b1, 1'b0); push(4'd5, 1'b1, 1'b0);
        // Load with three wait cycles in MEM_RD: eight cycles total
        cur_op = OP_LD;
        push(4'd1, 1'b1, 1'b0); push(4'd2, 1'b0, 1'b0); push(4'd6, 1'b0, 1'b0);
        push(4'd7, 1'b0, 1'b0); push(4'd7, 1'b0, 1'b0); push(4'd7, 1'b0, 1'b0); push(4'd7, 1'b1, 1'b0);
        push(4'd8, 1'b0, 1'b0);
        // Store with one fetch wait and one write wait
        cur_op = OP_ST;
        push(4'd1, 1'b0, 1'b0); push(4'd1, 1'b1, 1'b0); push(4'd2, 1'b0, 1'b0); push(4'd6, 1'b0, 1'b0);
        push(4'd9, 1'b0, 1'b0); push(4'd9, 1'b1, 1'b0);
        push_short(OP_BR, 4'd10, 1'b1);
        push_short(OP_BR, 4'd10, 1'b0);
        push_short(OP_JAL, 4'd11, 1'b0);
        push_short(OP_JALR, 4'd12, 1'b0);
        // run dropped mid-instruction: finish then park in IDLE
        cur_op = OP_R;
        push(4'd1, 1'b1, 1'b0); push(4'd2, 1'b0, 1'b0);
        cur_run = 1'b0;
        push(4'd3, 1'b0, 1'b0); push(4'd5, 1'b0, 1'b0); push(4'd0, 1'b0, 1'b0); push(4'd0, 1'b1, 1'b0);
        run_queue();
        check("load_req_hold", rd_hold, 32'd4);
`ifdef MULTICYCLE_CTRL_PERF_EN
        check("perf_cycles", perf_cycles, exp_cycles);
        check("perf_instret", perf_instret, exp_instret);
`endif

        // Illegal opcode: TRAP is sticky while run stays high
        cur_run = 1'b1; cur_op = OP_BAD;
        push(4'd0, 1'b0, 1'b0); push(4'd1, 1'b1, 1'b0); push(4'd2, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) push(4'd13, 1'b1, 1'b0);
        run_queue();
        #2 rstn = 1'b0;
        #1;
        check("trap_rst_state", {28'd0, dbg_state}, 32'd0);
        check("trap_rst_ill", {31'd0, illegal_insn}, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Reset during an outstanding store
        cur_op = OP_ST;
        push(4'd0, 1'b0, 1'b0); push(4'd1, 1'b1, 1'b0); push(4'd2, 1'b0, 1'b0); push(4'd6, 1'b0, 1'b0);
        run_queue();
        mem_ready = 1'b0;
        #2;
        check("wr_req_before", {30'd0, mem_req, mem_we}, 32'd3);
        rstn = 1'b0;
        #1;
        check("wr_req_abandon", {30'd0, mem_req, mem_we}, 32'd0);
        check("wr_rst_state", {28'd0, dbg_state}, 32'd0);
`ifdef MULTICYCLE_CTRL_PERF_EN
        check("perf_cycles_rst", perf_cycles, 32'd0);
        check("perf_instret_rst", perf_instret, 32'd0);
`endif
        @(posedge clk); #1;
        rstn = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
